i2s_rx_stream: RTL and testbench

//   Parametrised I2S / left-justified serial audio receiver, clocked entirely from the system clock.

---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_pin_sync.sv | 61 ++++++
 rtl/i2s_rx_stream.sv | 186 ++++++++++++++++++
 tb/tb_i2s_rx_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared encodings for the I2S / left-justified receiver: bus mode,
//            channel tag, bit-counter width and the boundary/word FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Bus framing mode, as presented on mode_lj
  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  // Channel tag on m_chan
  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

  // Slot bit counter width; the counter saturates at 2**BITCNT_W-1
  localparam int BITCNT_W = 6;

  typedef enum logic [0:0] {
    ST_IDLE_UNARMED = 1'b0,
    ST_RUN          = 1'b1
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pin_sync
// Purpose  : Brings bclk, lrclk and sdin into the clk domain through
//            SYNC_STAGES flops each and flags a rising edge of the synced bclk.
// Ports    : clk, rst_n      - system clock, synchronous active-low reset
//            bclk/lrclk/sdin - asynchronous serial pins
//            bclk_rise       - one-clk pulse on a synced bclk 0->1
//            lrclk_s/sdin_s  - synced lrclk and sdin, aligned with bclk_rise
// Revision : 1.0 - initial release
// ============================================================================
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdin,
  output logic bclk_rise,
  output logic lrclk_s,
  output logic sdin_s
);

  // One 3-bit lane per stage: [2]=sdin, [1]=lrclk, [0]=bclk
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [SYNC_STAGES-1:0][2:0] sync_d;
  logic                        bclk_prev_q;
  logic                        bclk_prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {sdin, lrclk, bclk};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    bclk_prev_d = sync_q[SYNC_STAGES-1][0];
  end

  // Synchroniser flops carry no reset: they flush within SYNC_STAGES clocks
  // and a reset here could fabricate an edge when the pin is already high.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  // Edge history resets high so a bclk that is high at reset release does
  // not register as a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_prev_q <= 1'b1;
    end else begin
      bclk_prev_q <= bclk_prev_d;
    end
  end

  assign bclk_rise = sync_q[SYNC_STAGES-1][0] & ~bclk_prev_q;
  assign lrclk_s   = sync_q[SYNC_STAGES-1][1];
  assign sdin_s    = sync_q[SYNC_STAGES-1][2];

endmodule
`default_nettype wire

// File: rtl/i2s_rx_stream.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_stream
// Purpose  : Oversampling I2S / left-justified receiver. Assembles MSB-first
//            DATA_WIDTH-bit words from SLOT_WIDTH-bit slots and presents them
//            with a channel tag on a one-deep valid/ready output register.
// Ports    : clk, rst_n         - system clock, synchronous active-low reset
//            mode_lj            - 0 = I2S, 1 = left-justified
//            bclk, lrclk, sdin  - asynchronous serial audio pins
//            m_data/m_chan      - received word and its channel (0 = left)
//            m_valid/m_ready    - output stream handshake
//            frame_err, overrun - sticky status, cleared by status_clr
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_stream
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_lj,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  sdin,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_chan,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  status_clr
);

  localparam int                 SLOT_LEN_W = BITCNT_W + 1;
  localparam logic [SLOT_LEN_W-1:0] SLOT_LEN = SLOT_LEN_W'(SLOT_WIDTH);

  logic bclk_rise;
  logic lrclk_s;
  logic sdin_s;

  i2s_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdin      (sdin),
    .bclk_rise (bclk_rise),
    .lrclk_s   (lrclk_s),
    .sdin_s    (sdin_s)
  );

  rx_state_e             state_q,      state_d;
  logic                  lrclk_prev_q, lrclk_prev_d;
  logic                  mode_q,       mode_d;
  logic [BITCNT_W-1:0]   cnt_q,        cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q,       sreg_d;
  logic [DATA_WIDTH-1:0] m_data_q,     m_data_d;
  logic                  m_chan_q,     m_chan_d;
  logic                  m_valid_q,    m_valid_d;
  logic                  frame_err_q,  frame_err_d;
  logic                  overrun_q,    overrun_d;

  logic                  boundary;
  logic                  emit;
  logic                  load;
  logic                  frame_set;
  logic                  over_set;
  logic [DATA_WIDTH-1:0] sreg_ins;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_chan;
  logic [SLOT_LEN_W-1:0] slot_len;

  always_comb begin
    state_d      = state_q;
    lrclk_prev_d = lrclk_prev_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    m_data_d     = m_data_q;
    m_chan_d     = m_chan_q;
    m_valid_d    = m_valid_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    // The bit counted as cnt_q lands at position DATA_WIDTH-1-cnt_q, so the
    // word is left-aligned as it arrives and bits past DATA_WIDTH find no slot.
    sreg_ins = sreg_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_q == BITCNT_W'(DATA_WIDTH - 1 - i)) begin
        sreg_ins[i] = sdin_s;
      end
    end

    boundary = bclk_rise && (lrclk_s != lrclk_prev_q);

    // In I2S the boundary bit is the LSB of the closing slot, so it is
    // included in both the word and the slot length.
    word     = (mode_q == MODE_I2S) ? sreg_ins : sreg_q;
    slot_len = (mode_q == MODE_I2S) ? ({1'b0, cnt_q} + 1'b1) : {1'b0, cnt_q};
    // The closing slot's lrclk level maps to a channel through its own mode.
    word_chan = (lrclk_prev_q ^ (mode_q == MODE_LJ)) ? CHAN_RIGHT : CHAN_LEFT;

    emit      = boundary && (state_q == ST_RUN);
    frame_set = emit && (slot_len != SLOT_LEN);
    load      = emit && (!m_valid_q || m_ready);
    over_set  = emit && !load;

    if (bclk_rise) begin
      lrclk_prev_d = lrclk_s;
      if (boundary) begin
        state_d = ST_RUN;
        mode_d  = mode_lj;
        sreg_d  = '0;
        if (mode_lj == MODE_LJ) begin
          sreg_d[DATA_WIDTH-1] = sdin_s;
          cnt_d                = BITCNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end else begin
        sreg_d = sreg_ins;
        cnt_d  = (cnt_q == {BITCNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      end
    end

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = word;
      m_chan_d  = word_chan;
    end

    // A new error event outranks a simultaneous clear.
    if (status_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_set) begin
      frame_err_d = 1'b1;
    end
    if (over_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE_UNARMED;
      lrclk_prev_q <= 1'b0;
      mode_q       <= MODE_I2S;
      cnt_q        <= '0;
      sreg_q       <= '0;
      m_data_q     <= '0;
      m_chan_q     <= CHAN_LEFT;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrclk_prev_q <= lrclk_prev_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      m_data_q     <= m_data_d;
      m_chan_q     <= m_chan_d;
      m_valid_q    <= m_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_chan    = m_chan_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_stream
// Purpose  : Directed bench for i2s_rx_stream: a 24/32 instance and a 16/16
//            instance share the serial bus; expected words are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_stream;

  localparam logic [23:0] L_W = 24'hA5A5A5;
  localparam logic [23:0] R_W = 24'h5A5A5A;
  localparam logic [63:0] J_SLOT   = 64'h0000_0000_FFFF_FF00;
  localparam logic [63:0] L_SLOT   = 64'h0000_0000_A5A5_A500;
  localparam logic [63:0] R_SLOT   = 64'h0000_0000_5A5A_5A00;
  localparam logic [63:0] L_SLOT30 = 64'h0000_0000_2969_6940;

  logic        clk;
  logic        rst_n;
  logic        mode_lj;
  logic        bclk;
  logic        lrclk;
  logic        sdin;
  logic        m_ready;
  logic        status_clr;
  logic [23:0] m_data;
  logic        m_chan;
  logic        m_valid;
  logic        frame_err;
  logic        overrun;
  logic [15:0] m16_data;
  logic        m16_chan;
  logic        m16_valid;
  logic        m16_frame_err;
  logic        m16_overrun;

  int          n_checks;
  int          n_errors;
  logic        pending;
  logic [32:0] q_main[$];
  logic [32:0] q16[$];

  i2s_rx_stream #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk (clk), .rst_n (rst_n), .mode_lj (mode_lj),
    .bclk (bclk), .lrclk (lrclk), .sdin (sdin),
    .m_data (m_data), .m_chan (m_chan), .m_valid (m_valid), .m_ready (m_ready),
    .frame_err (frame_err), .overrun (overrun), .status_clr (status_clr)
  );

  i2s_rx_stream #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .clk (clk), .rst_n (rst_n), .mode_lj (mode_lj),
    .bclk (bclk), .lrclk (lrclk), .sdin (sdin),
    .m_data (m16_data), .m_chan (m16_chan), .m_valid (m16_valid), .m_ready (m_ready),
    .frame_err (m16_frame_err), .overrun (m16_overrun), .status_clr (status_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every accepted word as {chan, zero-extended data}
  always @(negedge clk) begin
    if (m_valid && m_ready)   q_main.push_back({m_chan, 8'h00, m_data});
    if (m16_valid && m_ready) q16.push_back({m16_chan, 16'h0000, m16_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input logic use16, input int n,
                             input logic [32:0] e0, input logic [32:0] e1,
                             input logic [32:0] e2, input logic [32:0] e3);
    logic [32:0] ev [4];
    int          sz;
    ev = '{e0, e1, e2, e3};
    sz = use16 ? q16.size() : q_main.size();
    check({tag, "_count"}, 64'(sz), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < sz) begin
        check($sformatf("%s_w%0d", tag, i), 64'(use16 ? q16[i] : q_main[i]), 64'(ev[i]));
      end
    end
    q_main.delete();
    q16.delete();
  endtask

  // One bclk period: data changes while bclk is low, sampled on the rise
  task automatic bit_out(input logic lr, input logic d);
    bclk  = 1'b0;
    lrclk = lr;
    sdin  = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Slot of nbits rises; word holds the slot bits MSB-first in word[nbits-1:0].
  // I2S layout: the first rise carries the previous slot's LSB.
  task automatic send_slot(input logic lr, input logic [63:0] word, input int nbits,
                           input logic i2s);
    for (int j = 0; j < nbits; j++) begin
      if (i2s) bit_out(lr, (j == 0) ? pending : word[nbits - j]);
      else     bit_out(lr, word[nbits - 1 - j]);
    end
    if (i2s) pending = word[0];
  endtask

  task automatic do_reset();
    bclk    = 1'b0;
    lrclk   = 1'b0;
    sdin    = 1'b0;
    pending = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    q_main.delete();
    q16.delete();
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b1;
    mode_lj    = 1'b0;
    m_ready    = 1'b1;
    status_clr = 1'b0;
    bclk       = 1'b0;
    lrclk      = 1'b0;
    sdin       = 1'b0;
    pending    = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_chan", 64'(m_chan), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);

    // I2S stream; leading slot precedes the first boundary and is dropped
    send_slot(1'b0, J_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    bit_out(1'b1, pending);
    repeat (2) @(negedge clk);
    check_words("i2s", 1'b0, 4, {1'b1, 8'h0, R_W}, {1'b0, 8'h0, L_W},
                {1'b1, 8'h0, R_W}, {1'b0, 8'h0, L_W});
    check("i2s_ferr", 64'(frame_err), 64'd0);

    // Left-justified stream, lrclk high = left
    mode_lj = 1'b1;
    do_reset();
    send_slot(1'b0, J_SLOT, 32, 1'b0);
    send_slot(1'b1, L_SLOT, 32, 1'b0);
    send_slot(1'b0, R_SLOT, 32, 1'b0);
    send_slot(1'b1, L_SLOT, 32, 1'b0);
    send_slot(1'b0, R_SLOT, 32, 1'b0);
    bit_out(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_words("lj", 1'b0, 4, {1'b0, 8'h0, L_W}, {1'b1, 8'h0, R_W},
                {1'b0, 8'h0, L_W}, {1'b1, 8'h0, R_W});
    check("lj_ferr", 64'(frame_err), 64'd0);

    // I2S bus into an LJ receiver: one-bit shift and swapped channel tags
    do_reset();
    send_slot(1'b0, J_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    bit_out(1'b1, pending);
    repeat (2) @(negedge clk);
    check_words("lj_on_i2s", 1'b0, 4, {1'b0, 32'h002D2D2D}, {1'b1, 32'h0052D2D2},
                {1'b0, 32'h002D2D2D}, {1'b1, 32'h0052D2D2});

    // Backpressure: first word held, later words dropped
    mode_lj = 1'b0;
    m_ready = 1'b0;
    do_reset();
    send_slot(1'b0, J_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    check("bp_valid1", 64'(m_valid), 64'd1);
    check("bp_data1", 64'(m_data), 64'(R_W));
    check("bp_chan1", 64'(m_chan), 64'd1);
    check("bp_ovr1", 64'(overrun), 64'd0);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    check("bp_ovr2", 64'(overrun), 64'd1);
    check("bp_data2", 64'(m_data), 64'(R_W));
    check("bp_chan2", 64'(m_chan), 64'd1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    check("bp_data3", 64'(m_data), 64'(R_W));
    check("bp_ovr3", 64'(overrun), 64'd1);
    pulse_clr();
    check("bp_ovr_clr", 64'(overrun), 64'd0);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_valid_end", 64'(m_valid), 64'd0);
    check_words("bp", 1'b0, 1, {1'b1, 8'h0, R_W}, '0, '0, '0);

    // Short 30-bit slot: error flagged, word still delivered
    do_reset();
    send_slot(1'b0, J_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    check("fe_before", 64'(frame_err), 64'd0);
    send_slot(1'b0, L_SLOT30, 30, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    check("fe_set", 64'(frame_err), 64'd1);
    pulse_clr();
    check("fe_clr", 64'(frame_err), 64'd0);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    bit_out(1'b1, pending);
    repeat (2) @(negedge clk);
    check("fe_no_new", 64'(frame_err), 64'd0);
    check_words("fe", 1'b0, 4, {1'b1, 8'h0, R_W}, {1'b0, 8'h0, L_W},
                {1'b1, 8'h0, R_W}, {1'b0, 8'h0, L_W});

    // 16/16 instance with a 12-bit slot: left-aligned, zero padded
    do_reset();
    send_slot(1'b0, 64'hFFFF, 16, 1'b1);
    send_slot(1'b1, 64'h1234, 16, 1'b1);
    send_slot(1'b0, 64'h0ABC, 12, 1'b1);
    check("d16_ferr0", 64'(m16_frame_err), 64'd0);
    send_slot(1'b1, 64'h5678, 16, 1'b1);
    repeat (2) @(negedge clk);
    check("d16_ferr1", 64'(m16_frame_err), 64'd1);
    check_words("d16", 1'b1, 2, {1'b1, 32'h00001234}, {1'b0, 32'h0000ABC0}, '0, '0);

    // Reset pulse mid-slot with a held word and a pending overrun
    m_ready = 1'b0;
    do_reset();
    send_slot(1'b0, J_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 16, 1'b1);
    check("mr_valid_pre", 64'(m_valid), 64'd1);
    check("mr_ovr_pre", 64'(overrun), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_valid", 64'(m_valid), 64'd0);
    check("mr_data", 64'(m_data), 64'd0);
    check("mr_chan", 64'(m_chan), 64'd0);
    check("mr_ovr", 64'(overrun), 64'd0);
    check("mr_ferr", 64'(frame_err), 64'd0);
    m_ready = 1'b1;
    send_slot(1'b0, L_SLOT, 16, 1'b1);
    send_slot(1'b1, R_SLOT, 32, 1'b1);
    send_slot(1'b0, L_SLOT, 32, 1'b1);
    bit_out(1'b1, pending);
    repeat (2) @(negedge clk);
    check_words("mr", 1'b0, 2, {1'b1, 8'h0, R_W}, {1'b0, 8'h0, L_W}, '0, '0);
    check("mr_ferr_end", 64'(frame_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
